// File: rtl/fac0_pkg.sv
// ---------------------------------------------------------------------------
// fac0_pkg
// Shared defaults, lane-array types and the beat-counter width helper for the
// fac0 delay-feedback butterfly stage.
//   WIDTH_DEF / DATA_WIDTH_DEF / DEPTH_DEF : default sample width, lane count,
//                                            feedback depth
//   lane_arr_t     : DATA_WIDTH_DEF lanes of WIDTH_DEF-bit two's complement
//   lane_ext_arr_t : DATA_WIDTH_DEF lanes of WIDTH_DEF+1-bit two's complement
//   cnt_width()    : beat counter width for a given depth
//   CNT_W_DEF      : beat counter width at the default depth
// ---------------------------------------------------------------------------
package fac0_pkg;

    localparam int WIDTH_DEF      = 9;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_DEF      = 8;

    // One fill half plus one butterfly half make up a counter period.
    function automatic int cnt_width(input int depth);
        return $clog2(2 * depth);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);

    typedef logic [DATA_WIDTH_DEF-1:0][WIDTH_DEF-1:0] lane_arr_t;
    typedef logic [DATA_WIDTH_DEF-1:0][WIDTH_DEF:0]   lane_ext_arr_t;

endpackage

// File: rtl/fac0_delay_line.sv
// ---------------------------------------------------------------------------
// fac0_delay_line
// Enabled shift register of DEPTH entries, each holding LANES words of
// ENTRY_W bits. A new word enters at entry 0 on every enabled clock and the
// oldest entry is always visible on head.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every entry
//   en    : shift enable (one accepted beat)
//   din   : word written into entry 0
//   head  : entry DEPTH-1, the word written DEPTH enabled beats ago
// ---------------------------------------------------------------------------
module fac0_delay_line
    import fac0_pkg::*;
#(
    parameter int LANES   = DATA_WIDTH_DEF,
    parameter int ENTRY_W = WIDTH_DEF + 1,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [LANES-1:0][ENTRY_W-1:0]  din,
    output logic [LANES-1:0][ENTRY_W-1:0]  head
);

    logic [DEPTH-1:0][LANES-1:0][ENTRY_W-1:0] mem;

    // Whole-line shift: the new word lands in entry 0 and every other entry
    // moves one step towards the head. Nothing moves on idle clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (en) begin
            mem <= {mem[DEPTH-2:0], din};
        end
    end

    assign head = mem[DEPTH-1];

endmodule

// File: rtl/fac0_delay_feedback.sv
// ---------------------------------------------------------------------------
// fac0_delay_feedback
// Single-delay-feedback radix-2 stage controller. In the fill half of each
// period the incoming samples are parked in the delay line while the previous
// period's butterfly differences drain out. In the butterfly half the parked
// samples are offered to an external butterfly, its sums go out and its
// differences are parked. Every other period asks the butterfly for a -j
// rotation.
// Optional feature: define FAC0_FLUSH_EN to add a synchronous flush input.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   flush                       : (FAC0_FLUSH_EN only) synchronous restart,
//                                 wins over din_valid
//   din_valid                   : input beat strobe
//   din_re / din_im             : new samples, WIDTH bits per lane
//   din_shift_reg_re / _im      : delayed operand to the butterfly
//   fac8_0_cal                  : butterfly mode, 0 plain, 1 -j rotation
//   add_re/_im, sub_re/_im      : butterfly results, WIDTH+1 bits per lane
//   dout_re / dout_im           : registered stage output
//   dout_valid                  : output beat strobe
// All lane values are two's complement; each lane is processed on its own.
// ---------------------------------------------------------------------------
module fac0_delay_feedback
    import fac0_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
`ifdef FAC0_FLUSH_EN
    input  logic                              flush,
`endif
    input  logic                              din_valid,
    input  logic [DATA_WIDTH-1:0][WIDTH-1:0]  din_re,
    input  logic [DATA_WIDTH-1:0][WIDTH-1:0]  din_im,
    output logic [DATA_WIDTH-1:0][WIDTH-1:0]  din_shift_reg_re,
    output logic [DATA_WIDTH-1:0][WIDTH-1:0]  din_shift_reg_im,
    output logic                              fac8_0_cal,
    input  logic [DATA_WIDTH-1:0][WIDTH:0]    add_re,
    input  logic [DATA_WIDTH-1:0][WIDTH:0]    add_im,
    input  logic [DATA_WIDTH-1:0][WIDTH:0]    sub_re,
    input  logic [DATA_WIDTH-1:0][WIDTH:0]    sub_im,
    output logic [DATA_WIDTH-1:0][WIDTH:0]    dout_re,
    output logic [DATA_WIDTH-1:0][WIDTH:0]    dout_im,
    output logic                              dout_valid
);

    localparam int               CNT_W    = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DEPTH - 1);

    logic [CNT_W-1:0]              count;
    logic                          frame;
    logic                          primed;
    logic                          phase;
    logic                          step;
    logic [DATA_WIDTH-1:0][WIDTH:0] wr_re;
    logic [DATA_WIDTH-1:0][WIDTH:0] wr_im;
    logic [DATA_WIDTH-1:0][WIDTH:0] head_re;
    logic [DATA_WIDTH-1:0][WIDTH:0] head_im;
    logic [DATA_WIDTH-1:0][WIDTH:0] next_re;
    logic [DATA_WIDTH-1:0][WIDTH:0] next_im;

    // Counter MSB splits each period into the fill half and the butterfly half.
    assign phase      = count[CNT_W-1];
    assign fac8_0_cal = phase & frame;

    // A beat coinciding with flush is dropped entirely.
`ifdef FAC0_FLUSH_EN
    assign step = din_valid & ~flush;
`else
    assign step = din_valid;
`endif

    // Per-lane data steering. Fill half: park the sign-extended sample and
    // emit whatever leaves the head (last period's difference). Butterfly
    // half: park the difference and emit the sum. The head holds sign-extended
    // fill data during the butterfly half, so dropping its top bit is lossless.
    always_comb begin
        wr_re            = '0;
        wr_im            = '0;
        next_re          = '0;
        next_im          = '0;
        din_shift_reg_re = '0;
        din_shift_reg_im = '0;
        for (int l = 0; l < DATA_WIDTH; l++) begin
            if (phase) begin
                wr_re[l]   = sub_re[l];
                wr_im[l]   = sub_im[l];
                next_re[l] = add_re[l];
                next_im[l] = add_im[l];
            end else begin
                wr_re[l]   = {din_re[l][WIDTH-1], din_re[l]};
                wr_im[l]   = {din_im[l][WIDTH-1], din_im[l]};
                next_re[l] = head_re[l];
                next_im[l] = head_im[l];
            end
            din_shift_reg_re[l] = head_re[l][WIDTH-1:0];
            din_shift_reg_im[l] = head_im[l][WIDTH-1:0];
        end
    end

    fac0_delay_line #(
        .LANES   (DATA_WIDTH),
        .ENTRY_W (WIDTH + 1),
        .DEPTH   (DEPTH)
    ) u_line_re (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step),
        .din   (wr_re),
        .head  (head_re)
    );

    fac0_delay_line #(
        .LANES   (DATA_WIDTH),
        .ENTRY_W (WIDTH + 1),
        .DEPTH   (DEPTH)
    ) u_line_im (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step),
        .din   (wr_im),
        .head  (head_im)
    );

    // Period bookkeeping. DEPTH is a power of two, so the counter wraps from
    // 2*DEPTH-1 to 0 on its own; the frame bit flips on that wrap. primed
    // marks that at least one butterfly half has run, so the delay line now
    // holds real differences rather than reset zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            frame  <= 1'b0;
            primed <= 1'b0;
        end
`ifdef FAC0_FLUSH_EN
        else if (flush) begin
            count  <= '0;
            frame  <= 1'b0;
            primed <= 1'b0;
        end
`endif
        else if (din_valid) begin
            count  <= count + CNT_W'(1);
            primed <= primed | phase;
            if (count == CNT_LAST) begin
                frame <= ~frame;
            end
        end
    end

    // Output register. dout follows every accepted beat and holds across gaps;
    // dout_valid is suppressed until the first butterfly beat so that the
    // reset-zero drain of the first fill half is never reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_re    <= '0;
            dout_im    <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= step & (primed | phase);
            if (step) begin
                dout_re <= next_re;
                dout_im <= next_im;
            end
        end
    end

endmodule
